// File: rtl/lb_sched_if.sv
// lb_sched_if: bus bundle between the row scheduler, the pixel source,
// the three line-buffer write ports and the 3x3 convolution engine.
//   pixel stream : pix_valid, pix_data -> ; <- pix_ready
//   lb write     : lb_wr_en (one-hot LB1..LB3), lb_wr_addr, lb_wr_data
//   engine       : conv_data_valid, conv_k -> ; <- conv_ready, conv_rd_addr
// master = scheduler side, slave = source/buffers/engine side.
interface lb_sched_if;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       pix_ready;
  logic [2:0] lb_wr_en;
  logic [6:0] lb_wr_addr;
  logic [7:0] lb_wr_data;
  logic       conv_data_valid;
  logic [1:0] conv_k;
  logic       conv_ready;
  logic [6:0] conv_rd_addr;

  modport master (
    input  pix_valid, pix_data, conv_ready, conv_rd_addr,
    output pix_ready, lb_wr_en, lb_wr_addr, lb_wr_data, conv_data_valid, conv_k
  );
  modport slave (
    output pix_valid, pix_data, conv_ready, conv_rd_addr,
    input  pix_ready, lb_wr_en, lb_wr_addr, lb_wr_data, conv_data_valid, conv_k
  );
endinterface

// File: rtl/lb_sched.sv
// lb_sched: row scheduler for the 3x3 convolution engine.
// Writes a raster pixel stream round-robin into three line buffers and,
// once three rows are resident, launches one engine row pass per new row.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start       frame start pulse (honoured only when idle)
//   bus         lb_sched_if.master: pixel stream, line-buffer writes, engine
//   busy        high whenever not idle (registered)
//   frame_done  one-cycle pulse after the last row pass (registered)
module lb_sched #(
  parameter int IMG_W    = 100,
  parameter int IMG_H    = 100,
  parameter int LAST_COL = IMG_W - 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  lb_sched_if.master  bus,
  output logic        busy,
  output logic        frame_done
);
  localparam int RW = $clog2(IMG_H + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]    state, state_nxt;
  logic [6:0]    col;
  logic [1:0]    wsel, k;
  logic [RW-1:0] rows;
  logic          cdv_q;
  logic [1:0]    ck_q;
  logic          accept, row_end, pass_end;

  // Gating with rst keeps the reset cycle free of accepts and writes even
  // though state still shows FILL until the reset edge.
  assign bus.pix_ready  = (state == S_FILL) && !rst;
  assign accept         = bus.pix_valid && bus.pix_ready;
  assign row_end        = accept && (col == 7'(IMG_W - 1));
  // Only RUN looks at the read address: in LAUNCH it is stale from the
  // previous pass and must not end the new one.
  assign pass_end       = (state == S_RUN) && (bus.conv_rd_addr == 7'(LAST_COL));

  assign bus.lb_wr_en   = accept ? (3'b001 << wsel) : 3'b000;
  assign bus.lb_wr_addr = col;
  assign bus.lb_wr_data = bus.pix_data;

  assign bus.conv_data_valid = cdv_q;
  assign bus.conv_k          = ck_q;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FILL;
      S_FILL:   if (row_end && (int'(rows) + 1 >= 3)) state_nxt = S_LAUNCH;
      S_LAUNCH: if (!bus.conv_ready) state_nxt = S_RUN;
      S_RUN:    if (pass_end) state_nxt = (rows == RW'(IMG_H)) ? S_DONE : S_FILL;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      col        <= '0;
      wsel       <= '0;
      rows       <= '0;
      k          <= '0;
      cdv_q      <= 1'b0;
      ck_q       <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      // Valid rises entering LAUNCH and drops on the very edge RUN sees
      // LAST_COL, so the engine samples 0 when it goes back to idle.
      cdv_q      <= (state_nxt == S_LAUNCH) || (state_nxt == S_RUN);
      busy       <= (state_nxt != S_IDLE);
      frame_done <= (state_nxt == S_DONE);
      // One cycle behind k: k only moves on RUN exit, so conv_k stays
      // constant for the whole time valid is high.
      ck_q       <= k;

      if (state == S_IDLE && start) begin
        col  <= '0;
        wsel <= '0;
        rows <= '0;
        k    <= '0;
      end

      if (accept) begin
        if (row_end) begin
          col  <= '0;
          wsel <= (wsel == 2'd2) ? 2'd0 : wsel + 2'd1;
          rows <= rows + RW'(1);
        end else begin
          col  <= col + 7'd1;
        end
      end

      if (pass_end) k <= (k == 2'd2) ? 2'd0 : k + 2'd1;
    end
  end
endmodule

// File: doc/lb_sched.md
# lb_sched

Row scheduler for the 3×3 convolution engine. It accepts a raster pixel stream and writes it round-robin into the three 100-byte line buffers (LB1/LB2/LB3). Once three rows are resident, it launches one convolution row pass, holding `data_valid` and supplying the rotation index `k`, and detects the end of the pass from the engine's read address. It then accepts the next row, which overwrites the oldest buffer, and repeats until the frame is done. It sits between the pixel source, the line-buffer write ports and the convolution engine.

## Interface
Parameters:
- IMG_W, 100, pixels per row; line-buffer depth.
- IMG_H, 100, rows per frame (≥3).
- LAST_COL, 97, engine read address that marks the final MAC of a row (IMG_W-3).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame start pulse; honoured only in IDLE.
- pix_valid  in  1  source pixel valid.
- pix_data  in  8  source pixel.
- pix_ready  out  1  accept; high only in FILL.
- lb_wr_en  out  3  one-hot write enable: bit0=LB1, bit1=LB2, bit2=LB3.
- lb_wr_addr  out  7  column being written.
- lb_wr_data  out  8  byte being written.
- conv_data_valid  out  1  engine start/fetch qualifier.
- conv_k  out  2  row rotation index to engine (0..2).
- conv_ready  in  1  engine ready (low while a row pass runs).
- conv_rd_addr  in  7  engine's line-buffer read address.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse after last row pass.

## Operation
- State encoding is IDLE, FILL, LAUNCH, RUN, DONE. Internal state is `col` (7b), `wsel` (0..2), `rows` (rows written, 0..IMG_H) and `k`.
- IDLE: on `start`, clear `col`, `wsel`, `rows` and `k`, then go to FILL.
- FILL: the accept condition is `pix_valid & pix_ready`.
  - `lb_wr_en = accept ? (1<<wsel) : 0`, `lb_wr_addr = col`, `lb_wr_data = pix_data`. All three are combinational.
  - Each accept increments `col`.
  - An accept at `col==IMG_W-1` completes the row:
    - `col←0`, `wsel←(wsel+1)%3`, `rows←rows+1`.
    - Next state is LAUNCH if `rows+1≥3`; otherwise stay in FILL.
- LAUNCH: `conv_data_valid` is 1. Wait for `conv_ready==0` (engine has latched the start and cleared its read address), then go to RUN.
- RUN: `conv_data_valid` stays 1 so that each per-column fetch is qualified.
  - When `conv_rd_addr==LAST_COL`, clear `conv_data_valid` on that same edge. This guarantees the engine samples 0 when it returns to idle and does not restart.
  - On that edge, `k←(k+1)%3`.
  - Next state is DONE if `rows==IMG_H`, else FILL.
- DONE: pulse `frame_done` for one cycle, then go to IDLE.
- Rotation: rows 0,1,2,… go to LB1,LB2,LB3,LB1,…. The top row of the window is in LB(k+1); `k` equals (rows−3) mod 3 at each launch.
- `conv_k` is registered. It is stable from LAUNCH entry until one cycle after RUN exit, and never changes while `conv_data_valid` is high.
- `start` outside IDLE is ignored. `pix_valid` outside FILL is ignored, and no write occurs.

## Timing
- Reset: every registered output is 0 (`conv_data_valid`, `conv_k`, `busy`, `frame_done`). State is IDLE and all counters are 0. `pix_ready` and `lb_wr_en` are 0.
- Reset mid-operation has the same effect. Any write in the reset cycle is suppressed. The engine is expected to be reset alongside the block.
- `conv_data_valid` rises on the edge that enters LAUNCH. The engine sees it on the next edge, and `conv_ready` falls one edge later.
- `conv_rd_addr==LAST_COL` with `conv_ready==1` while in LAUNCH is stale data and must not end the pass. Only RUN checks the address.
- FILL→FILL across a row boundary costs no bubble; `pix_ready` stays high.
- Input throughput is one pixel per cycle in FILL.
- Per output row: IMG_W fill cycles, plus launch overhead of about 2 cycles, plus the engine pass of about 4·(LAST_COL+1) cycles.
- Frame latency from `start` to `frame_done` is at least IMG_H·IMG_W + (IMG_H−2)·(row-pass time).

## Test plan
- Reset: assert `rst` for 2 cycles with `pix_valid=1`. Required: all outputs 0, no `lb_wr_en`, state IDLE. `start` then gives `pix_ready=1` next cycle.
- Initial fill, IMG_W=100, IMG_H=5, continuous pixels with value = (row·100+col)&0xFF:
  - Writes go to LB1 addr 0..99, then LB2, then LB3.
  - `conv_data_valid` rises right after pixel 299 with `conv_k=0`.
  - `pix_ready=0` during LAUNCH and RUN.
- Engine model, where `conv_ready` falls 1 cycle after valid and `conv_rd_addr` steps 0..97 every 4 cycles:
  - `conv_data_valid` falls on the edge where `conv_rd_addr==97`.
  - The engine never restarts.
  - `conv_k` becomes 1.
  - The 4th row is written to LB1.
- Full frame, IMG_H=5: three launches with k=0,1,2, row writes to LB1,LB2,LB3,LB1,LB2, then one `frame_done` pulse. `busy` falls with the return to IDLE.
- Backpressure: toggle `pix_valid` randomly at 50%. Required: `lb_wr_addr` advances only on accepts, and there are no duplicate or missed columns.
- Stale-address guard: hold `conv_rd_addr=97` and `conv_ready=1` for 5 cycles in LAUNCH. Required: stay in LAUNCH with valid high until `conv_ready` falls. Also, `start` pulsed mid-frame has no effect.
